fifo_param: RTL

Parametrised synchronous FIFO, the next generation of the team's 8-bit single-clock FIFO. Adds configurable data width and depth, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and an optional first-word-fall-through read mode. Sits between any single-clock producer/consumer pair and replaces the fixed 8-bit FIFO in new datapaths.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_mem.sv | 39 +++
 rtl/fifo_param.sv | 117 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised FIFO family.
package fifo_pkg;

    localparam int FIFO_DEF_DATA_W = 8;
    localparam int FIFO_DEF_DEPTH  = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage for fifo_param: one synchronous write port, one read port.
// With FIFO_PARAM_FWFT_EN the read port is combinational, otherwise it is registered.
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
`ifndef FIFO_PARAM_FWFT_EN
    input  logic              rst,
    input  logic              rd_en,
`endif
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

`ifdef FIFO_PARAM_FWFT_EN
    assign rd_data = mem[rd_addr];
`else
    // A read of the slot being overwritten (full, read+write) returns the old word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
`endif

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with thresholds, sticky errors and flush.
// Define FIFO_PARAM_FWFT_EN for first-word-fall-through reads.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = FIFO_DEF_DATA_W,
    parameter int DEPTH    = FIFO_DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int AW      = clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rd_acc;
    logic          wr_acc;
    logic          ovf_set;
    logic          udf_set;
    logic [CW-1:0] count_nxt;

    // Flush masks both requests, so it never raises an error flag.
    assign rd_acc  = rd_en && !empty && !flush;
    assign wr_acc  = wr_en && (!full || rd_acc) && !flush;
    assign ovf_set = wr_en && full && !rd_acc && !flush;
    assign udf_set = rd_en && empty && !flush;

    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (wr_acc && !rd_acc) begin
            count_nxt = count + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
                if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
            end
            // Flags come from the next count so they move in step with count.
            count        <= count_nxt;
            full         <= (count_nxt == CW'(DEPTH));
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= CW'(AF_LEVEL));
            almost_empty <= (count_nxt <= CW'(AE_LEVEL));
            if (ovf_set) overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
            if (udf_set) underflow <= 1'b1;
            else if (clr_err) underflow <= 1'b0;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
`ifndef FIFO_PARAM_FWFT_EN
        .rst     (rst),
        .rd_en   (rd_acc),
`endif
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

`ifdef FIFO_PARAM_FWFT_EN
    assign rd_valid = !empty;
`else
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
        end
    end
`endif

endmodule
